// File: rtl/prbs_dac_shaper.sv
// Maps the PRBS chip stream to slew-limited bipolar DAC samples on an AXI-Stream
// master, with burst framing: ramp back to mid-scale after each burst, then report.
module prbs_dac_shaper #(
   parameter int DATA_W = 14,
   parameter int AXIS_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              chip_i,
   input  logic              busy_i,
   input  logic [DATA_W-1:0] amp_i,
   input  logic [7:0]        step_i,
   output logic [AXIS_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              active_o,
   output logic              burst_done_o,
   output logic [CNT_W-1:0]  burst_cnt_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_TAIL} state_t;

   localparam logic [DATA_W-1:0] AMP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

   state_t                    state_q, state_d;
   logic                      active_q, active_d;
   logic signed [DATA_W-1:0]  lvl_q, lvl_d;
   logic [DATA_W-1:0]         amp_lat_q, amp_lat_d;
   logic                      tvalid_q;
   logic [AXIS_W-1:0]         tdata_q, tdata_d;
   logic                      done_pend_q, done_pend_d;
   logic                      burst_done_q, burst_done_d;
   logic [CNT_W-1:0]          burst_cnt_q, burst_cnt_d;

   logic                      xfer;
   logic [DATA_W-1:0]         amp_sat;
   logic [DATA_W-1:0]         amp_eff;
   logic signed [DATA_W-1:0]  target;
   logic signed [DATA_W:0]    diff;
   logic [DATA_W:0]           diff_mag;
   logic [DATA_W:0]           step_ext;
   logic signed [DATA_W-1:0]  step_s;
   logic [AXIS_W-1:0]         lvl_ext;

   assign lvl_ext[DATA_W-1:0] = lvl_q;
   for (genvar gi = DATA_W; gi < AXIS_W; gi++) begin : g_sext
      assign lvl_ext[gi] = lvl_q[DATA_W-1];
   end

   assign step_ext = {{(DATA_W-7){1'b0}}, step_i};
   assign step_s   = {{(DATA_W-8){1'b0}}, step_i};

   always_comb begin
      state_d      = state_q;
      amp_lat_d    = amp_lat_q;
      lvl_d        = lvl_q;
      tdata_d      = tdata_q;
      done_pend_d  = 1'b0;
      burst_done_d = done_pend_q;
      burst_cnt_d  = burst_cnt_q;
      target       = '0;

      xfer    = tvalid_q & m_axis_tready;
      amp_sat = (amp_i > AMP_MAX) ? AMP_MAX : amp_i;
      // Entering ACTIVE uses the freshly latched amplitude on the same edge.
      amp_eff = (state_q == ST_ACTIVE) ? amp_lat_q : amp_sat;

      if (busy_i && state_q != ST_ACTIVE) begin
         amp_lat_d = amp_sat;
      end
      if (busy_i) begin
         target = chip_i ? $signed(amp_eff) : -$signed(amp_eff);
      end

      diff     = {target[DATA_W-1], target} - {lvl_q[DATA_W-1], lvl_q};
      diff_mag = diff[DATA_W] ? -diff : diff;

      if (xfer) begin
         tdata_d = lvl_ext;
         if (step_i == 8'd0 || diff_mag <= step_ext) begin
            lvl_d = target;
         end else if (diff[DATA_W]) begin
            lvl_d = lvl_q - step_s;
         end else begin
            lvl_d = lvl_q + step_s;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (busy_i) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!busy_i) state_d = ST_TAIL;
         end
         ST_TAIL: begin
            if (busy_i) begin
               state_d = ST_ACTIVE;
            end else if (xfer && lvl_d == '0) begin
               state_d     = ST_IDLE;
               done_pend_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pulse is delayed one stage so it lines up with tdata reaching zero.
      if (done_pend_q) begin
         burst_cnt_d = burst_cnt_q + 1'b1;
      end

      active_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q      <= ST_IDLE;
         active_q     <= 1'b0;
         lvl_q        <= '0;
         amp_lat_q    <= '0;
         tvalid_q     <= 1'b0;
         tdata_q      <= '0;
         done_pend_q  <= 1'b0;
         burst_done_q <= 1'b0;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         lvl_q        <= lvl_d;
         amp_lat_q    <= amp_lat_d;
         tvalid_q     <= 1'b1;
         tdata_q      <= tdata_d;
         done_pend_q  <= done_pend_d;
         burst_done_q <= burst_done_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign active_o      = active_q;
   assign burst_done_o  = burst_done_q;
   assign burst_cnt_o   = burst_cnt_q;

endmodule

// File: tb/tb_prbs_dac_shaper.sv
// Bench for prbs_dac_shaper: directed vector table, hand-written corner sequences,
// and randomized traffic checked against an integer-arithmetic reference model.
module tb_prbs_dac_shaper;

   logic        clk = 1'b0;
   logic        srst = 1'b1;
   logic        chip_i = 1'b0;
   logic        busy_i = 1'b0;
   logic [13:0] amp_i = '0;
   logic [7:0]  step_i = '0;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        active_o;
   logic        burst_done_o;
   logic [15:0] burst_cnt_o;

   prbs_dac_shaper #(.DATA_W(14), .AXIS_W(16), .CNT_W(16)) dut (
      .clk(clk), .srst(srst), .chip_i(chip_i), .busy_i(busy_i), .amp_i(amp_i),
      .step_i(step_i), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .active_o(active_o), .burst_done_o(burst_done_o),
      .burst_cnt_o(burst_cnt_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model: mode 0 idle, 1 emitting, 2 ramping down.
   int m_lvl = 0, m_amp = 0, m_mode = 0, m_tdata = 0, m_tvalid = 0;
   int m_pend = 0, m_done = 0, m_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic model(input logic rst, input logic b, input logic c,
                        input int a, input int s, input logic r);
      int xfer, sat, tgt, nl, d, done_now;
      if (rst) begin
         m_lvl = 0; m_amp = 0; m_mode = 0; m_tdata = 0; m_tvalid = 0;
         m_pend = 0; m_done = 0; m_cnt = 0;
         return;
      end
      xfer = (m_tvalid != 0 && r) ? 1 : 0;
      sat  = (a > 8191) ? 8191 : a;
      tgt  = 0;
      if (b) begin
         if (m_mode != 1) m_amp = sat;
         tgt = c ? m_amp : -m_amp;
      end
      nl = m_lvl;
      if (xfer != 0) begin
         d = tgt - m_lvl;
         if (s == 0 || (d < 0 ? -d : d) <= s) nl = tgt;
         else nl = m_lvl + ((d > 0) ? s : -s);
         m_tdata = m_lvl;
      end
      done_now = (m_mode == 2 && !b && xfer != 0 && nl == 0) ? 1 : 0;
      m_done = m_pend;
      if (m_pend != 0) m_cnt = (m_cnt + 1) % 65536;
      m_pend = done_now;
      if (b) m_mode = 1;
      else if (m_mode == 1) m_mode = 2;
      else if (done_now != 0) m_mode = 0;
      m_lvl = nl;
      m_tvalid = 1;
   endtask

   task automatic step(input logic rst, input logic b, input logic c,
                       input logic [13:0] a, input logic [7:0] s, input logic r);
      logic [15:0] exp_td;
      srst = rst; busy_i = b; chip_i = c; amp_i = a; step_i = s; m_axis_tready = r;
      @(posedge clk);
      #1;
      model(rst, b, c, int'(a), int'(s), r);
      exp_td = m_tdata[15:0];
      chk("mdl_tdata",  int'(m_axis_tdata), int'(exp_td));
      chk("mdl_tvalid", int'(m_axis_tvalid), m_tvalid);
      chk("mdl_active", int'(active_o), (m_mode != 0) ? 1 : 0);
      chk("mdl_done",   int'(burst_done_o), m_done);
      chk("mdl_cnt",    int'(burst_cnt_o), m_cnt);
   endtask

   typedef struct {
      logic        busy;
      logic        chip;
      logic [13:0] amp;
      logic [7:0]  stp;
      logic [15:0] exp_data;
      logic        exp_done;
      logic        exp_act;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic b, input logic c, input logic [13:0] a, input logic [7:0] s,
                      input logic [15:0] ed, input logic edn, input logic ea);
      vec_t v;
      v.busy = b; v.chip = c; v.amp = a; v.stp = s;
      v.exp_data = ed; v.exp_done = edn; v.exp_act = ea;
      vecs.push_back(v);
   endtask

   initial begin
      int seen;
      int pulses;

      // Burst 1: amp 1000, instantaneous slew, chips 1,0,1,1
      add(1, 1, 14'd1000, 8'd0, 16'h0000, 0, 1);
      add(1, 0, 14'd1000, 8'd0, 16'h03E8, 0, 1);
      add(1, 1, 14'd1000, 8'd0, 16'hFC18, 0, 1);
      add(1, 1, 14'd1000, 8'd0, 16'h03E8, 0, 1);
      add(0, 0, 14'd1000, 8'd0, 16'h03E8, 0, 1);
      add(0, 0, 14'd1000, 8'd0, 16'h0000, 0, 0);
      add(0, 0, 14'd1000, 8'd0, 16'h0000, 1, 0);
      add(0, 0, 14'd1000, 8'd0, 16'h0000, 0, 0);
      // Burst 2: amp 100, step 30, ramp up, hold, ramp down
      add(1, 1, 14'd100, 8'd30, 16'd0,   0, 1);
      add(1, 1, 14'd100, 8'd30, 16'd30,  0, 1);
      add(1, 1, 14'd100, 8'd30, 16'd60,  0, 1);
      add(1, 1, 14'd100, 8'd30, 16'd90,  0, 1);
      add(1, 1, 14'd100, 8'd30, 16'd100, 0, 1);
      add(1, 1, 14'd100, 8'd30, 16'd100, 0, 1);
      add(0, 1, 14'd100, 8'd30, 16'd100, 0, 1);
      add(0, 1, 14'd100, 8'd30, 16'd70,  0, 1);
      add(0, 1, 14'd100, 8'd30, 16'd40,  0, 1);
      add(0, 1, 14'd100, 8'd30, 16'd10,  0, 0);
      add(0, 1, 14'd100, 8'd30, 16'd0,   1, 0);
      add(0, 1, 14'd100, 8'd30, 16'd0,   0, 0);
      // Burst 3: amplitude request above full scale saturates to +/-8191
      add(1, 1, 14'h3FFF, 8'd0, 16'h0000, 0, 1);
      add(1, 0, 14'h3FFF, 8'd0, 16'h1FFF, 0, 1);
      add(0, 0, 14'h3FFF, 8'd0, 16'hE001, 0, 1);
      add(0, 0, 14'h3FFF, 8'd0, 16'h0000, 0, 0);
      add(0, 0, 14'h3FFF, 8'd0, 16'h0000, 1, 0);
      add(0, 0, 14'h3FFF, 8'd0, 16'h0000, 0, 0);

      // Reset and idle
      step(1, 0, 0, '0, '0, 1);
      step(1, 0, 0, '0, '0, 1);
      chk("rst_tvalid", int'(m_axis_tvalid), 0);
      chk("rst_tdata", int'(m_axis_tdata), 0);
      chk("rst_active", int'(active_o), 0);
      chk("rst_cnt", int'(burst_cnt_o), 0);
      step(0, 0, 0, '0, '0, 1);
      chk("post_rst_tvalid", int'(m_axis_tvalid), 1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, '0, '0, 1);
         if (burst_done_o) pulses++;
      end
      chk("idle_tdata", int'(m_axis_tdata), 0);
      chk("idle_no_pulse", pulses, 0);

      // Table-driven bursts
      for (int i = 0; i < vecs.size(); i++) begin
         step(0, vecs[i].busy, vecs[i].chip, vecs[i].amp, vecs[i].stp, 1);
         chk($sformatf("vec%0d_tdata", i), int'(m_axis_tdata), int'(vecs[i].exp_data));
         chk($sformatf("vec%0d_done", i), int'(burst_done_o), int'(vecs[i].exp_done));
         chk($sformatf("vec%0d_active", i), int'(active_o), int'(vecs[i].exp_act));
      end
      chk("table_cnt", int'(burst_cnt_o), 3);

      // Stall mid-ACTIVE, busy drops during the stall, ramp resumes afterwards
      for (int i = 0; i < 4; i++) step(0, 1, 1, 14'd500, 8'd50, 1);
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 1, 14'd500, 8'd50, 0);
         chk("stall_tdata", int'(m_axis_tdata), 150);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 14'd500, 8'd50, 0);
         chk("stall_tdata", int'(m_axis_tdata), 150);
         chk("stall_active", int'(active_o), 1);
      end
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         step(0, 0, 0, 14'd500, 8'd50, 1);
         if (burst_done_o) begin
            seen = 1;
            chk("stall_done_tdata", int'(m_axis_tdata), 0);
         end
      end
      chk("stall_done_seen", seen, 1);
      chk("stall_cnt", int'(burst_cnt_o), 4);

      // busy reasserted during TAIL at level 40
      for (int i = 0; i < 4; i++) step(0, 1, 1, 14'd100, 8'd30, 1);
      step(0, 0, 1, 14'd100, 8'd30, 1);
      step(0, 0, 1, 14'd100, 8'd30, 1);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, 14'd100, 8'd30, 1);
         if (burst_done_o) pulses++;
      end
      chk("reassert_no_pulse", pulses, 0);
      chk("reassert_cnt", int'(burst_cnt_o), 4);
      chk("reassert_active", int'(active_o), 1);
      chk("reassert_tdata", int'(m_axis_tdata), 100);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 14'd100, 8'd30, 1);
      chk("reassert_final_cnt", int'(burst_cnt_o), 5);

      // Reset pulsed mid-ACTIVE
      for (int i = 0; i < 3; i++) step(0, 1, 0, 14'd2000, 8'd0, 1);
      step(1, 1, 0, 14'd2000, 8'd0, 1);
      chk("mid_rst_tdata", int'(m_axis_tdata), 0);
      chk("mid_rst_active", int'(active_o), 0);
      chk("mid_rst_cnt", int'(burst_cnt_o), 0);
      chk("mid_rst_done", int'(burst_done_o), 0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 14'd2000, 8'd0, 1);
         if (burst_done_o) pulses++;
      end
      chk("mid_rst_no_pulse", pulses, 0);

      // Randomized traffic against the model
      begin
         logic        b, c, r, rs;
         logic [13:0] a;
         logic [7:0]  s;
         b = 0; a = 14'd1000; s = 8'd20;
         for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) b = ~b;
            if ($urandom_range(0, 19) == 0) a = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 19) == 0) s = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            c  = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 299) == 0);
            step(rs, b, c, a, s, r);
         end
         for (int i = 0; i < 200; i++) step(0, 0, 0, a, 8'd255, 1);
         chk("rand_final_idle", int'(active_o), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
